// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type
// and the address-decode helpers used to qualify and shape each access.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Unsigned variants only exist for loads; halfwords need even, words need 4-byte alignment.
    function automatic logic access_legal(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic       we,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [3:0] be;
        if (!we) begin
            be = 4'b1111;
        end else begin
            case (f3)
                F3_B:    be = 4'b0001 << off;
                F3_H:    be = 4'b0011 << {off[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [2:0]  f3,
                                                    input logic [31:0] wdata);
        logic [31:0] rep;
        case (f3)
            F3_B:    rep = {4{wdata[7:0]}};
            F3_H:    rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load alignment: selects the addressed byte/halfword/word from a
// raw memory word and sign- or zero-extends it to the register width.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [31:0] shifted_s;

    // Right-justify the addressed lane, then extend according to the load type.
    always_comb begin
        shifted_s = raw_word >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_BU:   load_data = {24'd0, shifted_s[7:0]};
            F3_HU:   load_data = {16'd0, shifted_s[15:0]};
            F3_W:    load_data = shifted_s;
            default: load_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage behind the ALU: issues one load/store at a time on a req/gnt/rvalid
// port, stalls the core while it is in flight and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_we,
    input  logic [2:0]            ex_funct3,
    input  logic [ADDR_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    output logic                  lsu_stall,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state_r;
    logic [2:0]            req_f3_r;
    logic [1:0]            req_off_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [3:0]            mem_be_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic                  lsu_rvalid_r;
    logic [DATA_WIDTH-1:0] lsu_rdata_r;
    logic                  lsu_err_r;

    logic                  legal_s;
    logic                  stall_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    load_align u_load_align (
        .raw_word  (mem_rdata),
        .byte_off  (req_off_r),
        .funct3    (req_f3_r),
        .load_data (load_data_s)
    );

    // Access qualification and the combinational stall seen by the core.
    always_comb begin
        legal_s = access_legal(ex_we, ex_funct3, ex_addr[1:0]);
        case (state_r)
            ST_IDLE: stall_s = ex_valid & legal_s;
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM with its request and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            req_f3_r     <= 3'd0;
            req_off_r    <= 2'd0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'd0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            lsu_rvalid_r <= 1'b0;
            lsu_rdata_r  <= {DATA_WIDTH{1'b0}};
            lsu_err_r    <= 1'b0;
        end else begin
            lsu_rvalid_r <= 1'b0;
            lsu_err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ex_valid && legal_s) begin
                        state_r     <= ST_REQ;
                        req_f3_r    <= ex_funct3;
                        req_off_r   <= ex_addr[1:0];
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= ex_we;
                        mem_be_r    <= byte_enable(ex_we, ex_funct3, ex_addr[1:0]);
                        mem_addr_r  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_r <= ex_we ? store_replicate(ex_funct3, ex_wdata)
                                             : {DATA_WIDTH{1'b0}};
                    end else if (ex_valid) begin
                        lsu_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        if (mem_we_r) begin
                            state_r <= ST_DONE;
                        end else if (mem_rvalid) begin
                            lsu_rdata_r  <= load_data_s;
                            lsu_rvalid_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        lsu_rdata_r  <= load_data_s;
                        lsu_rvalid_r <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                // The instruction still shown on ex_* is the one retiring; never re-issue it.
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign lsu_stall  = stall_s;
    assign lsu_rvalid = lsu_rvalid_r;
    assign lsu_rdata  = lsu_rdata_r;
    assign lsu_err    = lsu_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_be     = mem_be_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized
// accesses against a transaction-level reference model and a randomized memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_stall, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_stall(lsu_stall), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes, 0 for an illegal funct3.
    function automatic int ref_size(input bit we, input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            3'd4:    return we ? 0 : 1;
            3'd5:    return we ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = ref_size(we, f3);
        return (sz != 0) && ((int'(addr[1:0]) % sz) == 0);
    endfunction

    function automatic logic [3:0] ref_be(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        int off;
        sz  = ref_size(we, f3);
        off = int'(addr[1:0]);
        if (!we)      return 4'hF;
        else if (sz == 1) return 4'(1 << off);
        else if (sz == 2) return 4'(3 << off);
        else          return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0)      return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        else if (f3 == 3'd1) return {wd[15:0], wd[15:0]};
        else                 return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic [31:0] v;
        byte         sb;
        shortint     sh;
        v = word >> (8 * int'(addr[1:0]));
        case (f3)
            3'd0: begin sb = v[7:0];  return 32'(sb); end
            3'd1: begin sh = v[15:0]; return 32'(sh); end
            3'd4: return {24'd0, v[7:0]};
            3'd5: return {16'd0, v[15:0]};
            default: return v;
        endcase
    endfunction

    // One complete access as the core sees it; ex_valid is left high after a legal access
    // so that consecutive calls model back-to-back instructions.
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] word,
                              input int gnt_dly, input int rv_dly, input string tag,
                              output int stall_cnt);
        bit          legal;
        logic [31:0] exp_rd;
        stall_cnt = 0;
        @(negedge clk);
        check_val({tag, "_start_req"}, {31'd0, mem_req}, 32'd0);
        check_val({tag, "_start_rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        legal = ref_legal(we, f3, addr);
        check_val({tag, "_issue_stall"}, {31'd0, lsu_stall}, {31'd0, legal});
        if (!legal) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            check_val({tag, "_err"}, {31'd0, lsu_err}, 32'd1);
            check_val({tag, "_err_req"}, {31'd0, mem_req}, 32'd0);
            check_val({tag, "_err_stall"}, {31'd0, lsu_stall}, 32'd0);
            @(negedge clk);
            #1;
            check_val({tag, "_err_pulse"}, {31'd0, lsu_err}, 32'd0);
            check_val({tag, "_err_rdata"}, lsu_rdata, last_rdata);
            return;
        end
        for (int c = 0; c <= gnt_dly; c++) begin
            @(negedge clk);
            mem_gnt    = (c == gnt_dly);
            mem_rvalid = (c < gnt_dly) ? 1'($urandom_range(0, 1)) : (!we && rv_dly == 0);
            mem_rdata  = (c == gnt_dly && mem_rvalid) ? word : $urandom();
            #1;
            stall_cnt += int'(lsu_stall);
            check_val({tag, "_req"}, {31'd0, mem_req}, 32'd1);
            check_val({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
            check_val({tag, "_be"}, {28'd0, mem_be}, {28'd0, ref_be(we, f3, addr)});
            check_val({tag, "_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            if (we) check_val({tag, "_wdata"}, mem_wdata, ref_wdata(f3, wdata));
        end
        if (!we) begin
            for (int c = 1; c <= rv_dly; c++) begin
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = (c == rv_dly);
                mem_rdata  = mem_rvalid ? word : $urandom();
                #1;
                stall_cnt += int'(lsu_stall);
                check_val({tag, "_wait_req"}, {31'd0, mem_req}, 32'd0);
            end
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom();
        #1;
        check_val({tag, "_done_stall"}, {31'd0, lsu_stall}, 32'd0);
        check_val({tag, "_done_rvalid"}, {31'd0, lsu_rvalid}, {31'd0, !we});
        check_val({tag, "_done_req"}, {31'd0, mem_req}, 32'd0);
        exp_rd = we ? last_rdata : ref_load(word, f3, addr);
        check_val({tag, "_rdata"}, lsu_rdata, exp_rd);
        last_rdata = exp_rd;
        check_val({tag, "_stall_cycles"}, 32'(stall_cnt),
                  32'(gnt_dly + 1 + (we ? 0 : rv_dly)));
    endtask

    // A stray response while idle must not produce a load result.
    task automatic idle_stale(input string tag);
        @(negedge clk);
        ex_valid   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom();
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check_val({tag, "_rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
        check_val({tag, "_rdata"}, lsu_rdata, last_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
        check_val({tag, "_rvalid"}, {31'd0, lsu_rvalid}, 32'd0);
        check_val({tag, "_rdata"}, lsu_rdata, 32'd0);
        check_val({tag, "_err"}, {31'd0, lsu_err}, 32'd0);
        check_val({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        check_val({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check_val({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        check_val({tag, "_addr"}, mem_addr, 32'd0);
        check_val({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int          sa;
        bit          rwe;
        logic [2:0]  rf3;
        rst = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'd0; ex_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        run_access(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 1, "lb", sa);
        check_val("lb_stall_after_issue", 32'(sa), 32'd2);
        run_access(1'b0, 3'd5, 32'h0000_0102, 32'd0, 32'hBEEF_0000, 0, 0, "lhu", sa);
        check_val("lhu_no_wait", 32'(sa), 32'd1);
        run_access(1'b1, 3'd0, 32'h0000_0201, 32'h0000_00AB, 32'd0, 3, 0, "sb", sa);
        run_access(1'b0, 3'd2, 32'h0000_0102, 32'd0, 32'd0, 0, 0, "lw_misaligned", sa);
        run_access(1'b1, 3'd3, 32'h0000_0100, 32'h1234_5678, 32'd0, 0, 0, "sw_f3_3", sa);
        run_access(1'b1, 3'd2, 32'h0000_0400, 32'hDEAD_BEEF, 32'd0, 1, 0, "b2b_sw", sa);
        run_access(1'b0, 3'd2, 32'h0000_0404, 32'd0, 32'h1234_5678, 0, 1, "b2b_lw", sa);
        run_access(1'b1, 3'd1, 32'h0000_0506, 32'h0000_CAFE, 32'd0, 0, 0, "sh_hi", sa);
        run_access(1'b0, 3'd1, 32'h0000_0506, 32'd0, 32'h8001_7FFF, 2, 2, "lh_neg", sa);
        idle_stale("stale_idle");

        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
            if (!rwe && $urandom_range(0, 2) == 0) rf3 = 3'($urandom_range(4, 5));
            run_access(rwe, rf3, $urandom(), $urandom(), $urandom(),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand", sa);
            if ($urandom_range(0, 3) == 0) idle_stale("rand_stale");
        end

        // Reset in the middle of a load that is waiting for its data.
        @(negedge clk);
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h0000_0300;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check_val("rst_wait_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_wait_stall", {31'd0, lsu_stall}, 32'd1);
        ex_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_release");
        last_rdata = 32'd0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check_val("rst_late_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        check_val("rst_late_rdata", lsu_rdata, 32'd0);
        check_val("rst_late_req", {31'd0, mem_req}, 32'd0);
        run_access(1'b0, 3'd4, 32'h0000_0301, 32'd0, 32'h0000_9A00, 1, 0, "post_rst_lbu", sa);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
